// File: rtl/alu_op_sequencer.sv
// Registered ALU control decoder with valid/ready handshakes and a busy counter for multi-cycle MUL/DIV.
// Define RV32M_EN to decode and sequence M-extension ops; otherwise they are reported as illegal.
module alu_op_sequencer #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush_i,
  input  logic       dec_valid_i,
  output logic       dec_ready_o,
  input  logic [1:0] ALUOp,
  input  logic [2:0] funct3,
  input  logic       op_5,
  input  logic       funct7_5,
  input  logic       funct7_0,
  output logic [4:0] ALUControl,
  output logic       ctrl_valid_o,
  input  logic       ctrl_ready_i,
  output logic       mdu_busy_o,
  output logic       illegal_o
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, MDU} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       ctrl_q, ctrl_d;
  logic             illegal_q, illegal_d;
  logic             valid_q, valid_d;

  logic [4:0] dec_ctrl;
  logic       dec_illegal;
  logic       dec_mdu;
  logic       dec_multi;
  logic       accept;

  always_comb begin
    dec_ctrl    = '0;
    dec_illegal = 1'b0;
    dec_mdu     = 1'b0;
    case (ALUOp)
      2'b00: dec_ctrl = 5'b00000;
      2'b01: dec_ctrl = 5'b00001;
      2'b11: begin
        case (funct3[2:1])
          2'b00:   dec_ctrl = 5'b00001;
          2'b10:   dec_ctrl = 5'b00101;
          2'b11:   dec_ctrl = 5'b00110;
          default: dec_illegal = 1'b1;
        endcase
      end
      default: begin
        if (op_5 && funct7_0) begin
`ifdef RV32M_EN
          dec_ctrl = {2'b10, funct3};
          dec_mdu  = 1'b1;
`else
          dec_illegal = 1'b1;
`endif
        end else begin
          case (funct3)
            3'b000:  dec_ctrl = (op_5 && funct7_5) ? 5'b00001 : 5'b00000;
            3'b001:  dec_ctrl = 5'b00111;
            3'b010:  dec_ctrl = 5'b00101;
            3'b011:  dec_ctrl = 5'b00110;
            3'b100:  dec_ctrl = 5'b00100;
            3'b101:  dec_ctrl = funct7_5 ? 5'b01001 : 5'b01000;
            3'b110:  dec_ctrl = 5'b00011;
            default: dec_ctrl = 5'b00010;
          endcase
        end
      end
    endcase
  end

  // funct3[2] separates DIV/REM from the MUL family
  assign dec_multi   = dec_mdu && (funct3[2] ? (DIV_CYCLES > 1) : (MUL_CYCLES > 1));
  assign dec_ready_o = !flush_i && (state_q == IDLE) && (!valid_q || ctrl_ready_i);
  assign accept      = dec_valid_i && dec_ready_o;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ctrl_d    = ctrl_q;
    illegal_d = illegal_q;
    valid_d   = valid_q;
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else begin
      if (valid_q && ctrl_ready_i) valid_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            ctrl_d    = dec_ctrl;
            illegal_d = dec_illegal;
            if (dec_multi) begin
              cnt_d   = funct3[2] ? DIV_LOAD : MUL_LOAD;
              state_d = MDU;
            end else begin
              valid_d = 1'b1;
            end
          end
        end
        default: begin
          if (cnt_q == CNT_W'(1)) begin
            valid_d = 1'b1;
            state_d = IDLE;
          end
          if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
      valid_q   <= valid_d;
    end
  end

  assign ALUControl   = ctrl_q;
  assign illegal_o    = illegal_q;
  assign ctrl_valid_o = valid_q;
`ifdef RV32M_EN
  assign mdu_busy_o = (state_q == MDU);
`else
  assign mdu_busy_o = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: decode table, handshake hold/back-to-back, flush, reset, M-op timing.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush_i;
  logic       dec_valid_i;
  logic       dec_ready_o;
  logic [1:0] ALUOp;
  logic [2:0] funct3;
  logic       op_5;
  logic       funct7_5;
  logic       funct7_0;
  logic [4:0] ALUControl;
  logic       ctrl_valid_o;
  logic       ctrl_ready_i;
  logic       mdu_busy_o;
  logic       illegal_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] op;
    logic [2:0] f3;
    logic       o5;
    logic       f75;
    logic       f70;
    logic [4:0] ctrl;
    logic       ill;
  } vec_t;

  vec_t vecs[17];

  alu_op_sequencer #(.MUL_CYCLES(2), .DIV_CYCLES(32)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i),
    .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
    .ALUOp(ALUOp), .funct3(funct3), .op_5(op_5), .funct7_5(funct7_5), .funct7_0(funct7_0),
    .ALUControl(ALUControl), .ctrl_valid_o(ctrl_valid_o), .ctrl_ready_i(ctrl_ready_i),
    .mdu_busy_o(mdu_busy_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [4:0] c, input logic il);
    check({tag, "_valid"}, ctrl_valid_o, v);
    check({tag, "_ctrl"}, ALUControl, c);
    check({tag, "_illegal"}, illegal_o, il);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic o5,
                       input logic f75, input logic f70);
    ALUOp       = op;
    funct3      = f3;
    op_5        = o5;
    funct7_5    = f75;
    funct7_0    = f70;
    dec_valid_i = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{2'b10, 3'b101, 1'b0, 1'b1, 1'b0, 5'b01001, 1'b0};
    vecs[1]  = '{2'b10, 3'b000, 1'b1, 1'b1, 1'b0, 5'b00001, 1'b0};
    vecs[2]  = '{2'b11, 3'b000, 1'b0, 1'b0, 1'b0, 5'b00001, 1'b0};
    vecs[3]  = '{2'b11, 3'b101, 1'b0, 1'b0, 1'b0, 5'b00101, 1'b0};
    vecs[4]  = '{2'b11, 3'b110, 1'b0, 1'b0, 1'b0, 5'b00110, 1'b0};
    vecs[5]  = '{2'b11, 3'b010, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b1};
    vecs[6]  = '{2'b00, 3'b111, 1'b1, 1'b1, 1'b1, 5'b00000, 1'b0};
    vecs[7]  = '{2'b01, 3'b011, 1'b0, 1'b0, 1'b0, 5'b00001, 1'b0};
    vecs[8]  = '{2'b10, 3'b001, 1'b1, 1'b0, 1'b0, 5'b00111, 1'b0};
    vecs[9]  = '{2'b10, 3'b010, 1'b1, 1'b0, 1'b0, 5'b00101, 1'b0};
    vecs[10] = '{2'b10, 3'b011, 1'b0, 1'b0, 1'b0, 5'b00110, 1'b0};
    vecs[11] = '{2'b10, 3'b100, 1'b1, 1'b0, 1'b0, 5'b00100, 1'b0};
    vecs[12] = '{2'b10, 3'b101, 1'b1, 1'b0, 1'b0, 5'b01000, 1'b0};
    vecs[13] = '{2'b10, 3'b110, 1'b1, 1'b0, 1'b0, 5'b00011, 1'b0};
    vecs[14] = '{2'b10, 3'b111, 1'b1, 1'b0, 1'b0, 5'b00010, 1'b0};
    vecs[15] = '{2'b10, 3'b000, 1'b0, 1'b1, 1'b0, 5'b00000, 1'b0};
    vecs[16] = '{2'b10, 3'b000, 1'b0, 1'b0, 1'b1, 5'b00000, 1'b0};

    reset = 1'b1; flush_i = 1'b0; dec_valid_i = 1'b0; ctrl_ready_i = 1'b1;
    ALUOp = 2'b00; funct3 = 3'b000; op_5 = 1'b0; funct7_5 = 1'b0; funct7_0 = 1'b0;
    #12;
    expect_out("reset", 1'b0, 5'b00000, 1'b0);
    check("reset_busy", mdu_busy_o, 1'b0);
    reset = 1'b0;
    tick();
    check("reset_ready", dec_ready_o, 1'b1);

    // back-to-back stream of single-cycle ops with the consumer always ready
    for (int unsigned i = 0; i < 17; i++) begin
      drive(vecs[i].op, vecs[i].f3, vecs[i].o5, vecs[i].f75, vecs[i].f70);
      tick();
      dec_valid_i = 1'b0;
      expect_out($sformatf("vec%0d", i), 1'b1, vecs[i].ctrl, vecs[i].ill);
      check($sformatf("vec%0d_ready", i), dec_ready_o, 1'b1);
      check($sformatf("vec%0d_busy", i), mdu_busy_o, 1'b0);
    end
    tick();
    check("drain_valid", ctrl_valid_o, 1'b0);

    // hold under back-pressure, then consume and accept in the same cycle
    ctrl_ready_i = 1'b0;
    drive(2'b10, 3'b100, 1'b1, 1'b0, 1'b0);
    tick();
    drive(2'b10, 3'b111, 1'b1, 1'b0, 1'b0);
    expect_out("hold0", 1'b1, 5'b00100, 1'b0);
    check("hold0_ready", dec_ready_o, 1'b0);
    tick();
    expect_out("hold1", 1'b1, 5'b00100, 1'b0);
    ctrl_ready_i = 1'b1;
    tick();
    dec_valid_i = 1'b0;
    ctrl_ready_i = 1'b0;
    expect_out("swap", 1'b1, 5'b00010, 1'b0);
    tick();
    expect_out("swap_hold", 1'b1, 5'b00010, 1'b0);

    // flush drops the held result and the request presented alongside it
    flush_i = 1'b1;
    drive(2'b10, 3'b110, 1'b1, 1'b0, 1'b0);
    check("flush_ready", dec_ready_o, 1'b0);
    tick();
    flush_i = 1'b0;
    dec_valid_i = 1'b0;
    check("flush_valid", ctrl_valid_o, 1'b0);
    tick();
    check("flush_drop_valid", ctrl_valid_o, 1'b0);
    check("flush_after_ready", dec_ready_o, 1'b1);

    // asynchronous reset while a result is held
    drive(2'b10, 3'b001, 1'b1, 1'b0, 1'b0);
    tick();
    dec_valid_i = 1'b0;
    expect_out("prereset", 1'b1, 5'b00111, 1'b0);
    reset = 1'b1;
    #1;
    expect_out("async_reset", 1'b0, 5'b00000, 1'b0);
    reset = 1'b0;
    ctrl_ready_i = 1'b1;
    tick();
    check("async_reset_ready", dec_ready_o, 1'b1);

`ifdef RV32M_EN
    // MUL: busy for one cycle, result two cycles after accept
    drive(2'b10, 3'b000, 1'b1, 1'b0, 1'b1);
    tick();
    dec_valid_i = 1'b0;
    check("mul_busy", mdu_busy_o, 1'b1);
    check("mul_early_valid", ctrl_valid_o, 1'b0);
    check("mul_busy_ready", dec_ready_o, 1'b0);
    tick();
    expect_out("mul", 1'b1, 5'b10000, 1'b0);
    check("mul_done_busy", mdu_busy_o, 1'b0);
    tick();
    check("mul_drain", ctrl_valid_o, 1'b0);

    // DIVU with back-pressure: result after 32 cycles and held until consumed
    ctrl_ready_i = 1'b0;
    drive(2'b10, 3'b101, 1'b1, 1'b0, 1'b1);
    tick();
    dec_valid_i = 1'b0;
    for (int unsigned i = 1; i < 32; i++) begin
      check($sformatf("divu_wait%0d_valid", i), ctrl_valid_o, 1'b0);
      check($sformatf("divu_wait%0d_ready", i), dec_ready_o, 1'b0);
      check($sformatf("divu_wait%0d_busy", i), mdu_busy_o, 1'b1);
      tick();
    end
    for (int unsigned i = 0; i < 3; i++) begin
      expect_out($sformatf("divu_hold%0d", i), 1'b1, 5'b10101, 1'b0);
      check($sformatf("divu_hold%0d_ready", i), dec_ready_o, 1'b0);
      check($sformatf("divu_hold%0d_busy", i), mdu_busy_o, 1'b0);
      tick();
    end
    ctrl_ready_i = 1'b1;
    tick();
    check("divu_consumed", ctrl_valid_o, 1'b0);

    // flush during the fifth cycle of a DIV
    drive(2'b10, 3'b100, 1'b1, 1'b0, 1'b1);
    tick();
    dec_valid_i = 1'b0;
    for (int unsigned i = 0; i < 4; i++) tick();
    check("div_flush_pre_busy", mdu_busy_o, 1'b1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("div_flush_busy", mdu_busy_o, 1'b0);
    check("div_flush_valid", ctrl_valid_o, 1'b0);
    check("div_flush_ready", dec_ready_o, 1'b1);
    for (int unsigned i = 0; i < 30; i++) tick();
    check("div_flush_no_result", ctrl_valid_o, 1'b0);

    // reset mid-DIV when the counter reads 17
    drive(2'b10, 3'b101, 1'b1, 1'b0, 1'b1);
    tick();
    dec_valid_i = 1'b0;
    for (int unsigned i = 0; i < 14; i++) tick();
    check("div_mid_busy", mdu_busy_o, 1'b1);
    reset = 1'b1;
    #1;
    expect_out("div_reset", 1'b0, 5'b00000, 1'b0);
    check("div_reset_busy", mdu_busy_o, 1'b0);
    reset = 1'b0;
    tick();
    check("div_reset_ready", dec_ready_o, 1'b1);
    for (int unsigned i = 0; i < 20; i++) tick();
    check("div_reset_no_result", ctrl_valid_o, 1'b0);
`else
    // without the M extension a MUL encoding is a one-cycle illegal op
    drive(2'b10, 3'b000, 1'b1, 1'b0, 1'b1);
    tick();
    dec_valid_i = 1'b0;
    expect_out("mul_illegal", 1'b1, 5'b00000, 1'b1);
    check("mul_illegal_busy", mdu_busy_o, 1'b0);
    drive(2'b10, 3'b101, 1'b1, 1'b0, 1'b1);
    tick();
    dec_valid_i = 1'b0;
    expect_out("divu_illegal", 1'b1, 5'b00000, 1'b1);
    check("divu_illegal_busy", mdu_busy_o, 1'b0);
    check("divu_illegal_ready", dec_ready_o, 1'b1);
    tick();
    check("illegal_drain", ctrl_valid_o, 1'b0);
    check("illegal_drain_busy", mdu_busy_o, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
